// File: rtl/lin2log_converter.sv
// Linear-to-log2 front end for the shift-based log-domain adder.
// A signed fixed-point sample becomes a sign bit plus a signed log2 magnitude. The
// log uses the Mitchell approximation: the exponent is the leading-one position,
// and the fraction is the mantissa bits below that leading one.
// There are three pipeline stages: sign/magnitude, leading-one detect, assemble.
// All stages share one enable, so bubbles stay where they are.
module lin2log_converter #(
  parameter int unsigned IN_W     = 16,
  parameter int unsigned IN_FRAC  = 8,
  parameter int unsigned LOG_W    = 18,
  parameter int unsigned LOG_FRAC = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [LOG_W-1:0] out_log,
  output logic             out_sign,
  output logic             out_zero,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned PosW  = $clog2(IN_W);
  // The mantissa is widened by LOG_FRAC zero bits.
  // Small exponents then still fill every fraction bit after normalisation.
  localparam int unsigned NormW = IN_W + LOG_FRAC;
  // Zero input maps to the most negative log code. The adder treats it as -infinity.
  localparam logic [LOG_W-1:0] NegInf = {1'b1, {(LOG_W-1){1'b0}}};

  // Shared pipeline enable. The last stage is either empty or being drained.
  logic en;

  // Stage 1 registers: sign, magnitude, zero flag.
  logic            s1_valid_q;
  logic            s1_sign_q,  s1_sign_d;
  logic [IN_W-1:0] s1_mag_q,   s1_mag_d;
  logic            s1_zero_q,  s1_zero_d;

  // Stage 2 registers: stage 1 data plus the leading-one position.
  logic            s2_valid_q;
  logic            s2_sign_q;
  logic            s2_zero_q;
  logic [IN_W-1:0] s2_mag_q;
  logic [PosW-1:0] s2_pos_q,   s2_pos_d;

  // Stage 3 (output) registers.
  logic             out_valid_q;
  logic [LOG_W-1:0] out_log_q,  out_log_d;
  logic             out_sign_q;
  logic             out_zero_q;

  // Stage 3 combinational intermediates.
  logic [NormW-1:0]    norm;
  logic [LOG_FRAC-1:0] frac;
  logic [LOG_W-1:0]    exp_k;

  // Handshake: the pipeline moves unless a result is held waiting for downstream.
  always_comb begin
    en       = !out_valid_q || out_ready;
    in_ready = en;
  end

  // Stage 1: split the sign from the magnitude.
  // Two's-complement negation of the most negative input wraps to 2^(IN_W-1).
  // That value is the correct unsigned magnitude.
  always_comb begin
    s1_sign_d = in_data[IN_W-1];
    s1_mag_d  = s1_sign_d ? (~in_data + IN_W'(1)) : in_data;
    s1_zero_d = (in_data == '0);
  end

  // Stage 2: find the leading one. The highest set bit wins.
  // The result is unused when the magnitude is zero.
  always_comb begin
    s2_pos_d = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (s1_mag_q[i]) begin
        s2_pos_d = PosW'(i);
      end
    end
  end

  // Stage 3: normalise the leading one to the top bit.
  // The next LOG_FRAC bits become the fraction, truncated with no rounding.
  always_comb begin
    norm      = {s2_mag_q, {LOG_FRAC{1'b0}}} << (PosW'(IN_W - 1) - s2_pos_q);
    frac      = norm[NormW-2 -: LOG_FRAC];
    // The exponent is unbiased by the input's fraction width; modulo-2^LOG_W math keeps it signed.
    exp_k     = LOG_W'(s2_pos_q) - LOG_W'(IN_FRAC);
    out_log_d = s2_zero_q ? NegInf : ((exp_k << LOG_FRAC) | LOG_W'(frac));
  end

  // Pipeline registers. All stages advance together on en and are cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_mag_q    <= '0;
      s1_zero_q   <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_sign_q   <= 1'b0;
      s2_zero_q   <= 1'b0;
      s2_mag_q    <= '0;
      s2_pos_q    <= '0;
      out_valid_q <= 1'b0;
      out_log_q   <= '0;
      out_sign_q  <= 1'b0;
      out_zero_q  <= 1'b0;
    end else if (en) begin
      s1_valid_q  <= in_valid;
      s1_sign_q   <= s1_sign_d;
      s1_mag_q    <= s1_mag_d;
      s1_zero_q   <= s1_zero_d;
      s2_valid_q  <= s1_valid_q;
      s2_sign_q   <= s1_sign_q;
      s2_zero_q   <= s1_zero_q;
      s2_mag_q    <= s1_mag_q;
      s2_pos_q    <= s2_pos_d;
      out_valid_q <= s2_valid_q;
      out_log_q   <= out_log_d;
      out_sign_q  <= s2_sign_q;
      out_zero_q  <= s2_zero_q;
    end
  end

  // Drive the output ports from the stage 3 registers.
  always_comb begin
    out_valid = out_valid_q;
    out_log   = out_log_q;
    out_sign  = out_sign_q;
    out_zero  = out_zero_q;
  end

endmodule

// File: tb/tb_lin2log_converter.sv
// Directed and randomised checks for lin2log_converter, using an in-order scoreboard.
module tb_lin2log_converter;

  logic        clk;
  logic        rst_n;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [17:0] out_log;
  logic        out_sign;
  logic        out_zero;
  logic        out_valid;
  logic        out_ready;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [19:0] sb[$];
  logic        stall_prev = 1'b0;
  logic [19:0] held       = '0;

  lin2log_converter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_log   (out_log),
    .out_sign  (out_sign),
    .out_zero  (out_zero),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Mitchell reference model. Returns {sign, zero, log}.
  function automatic logic [19:0] model(input logic [15:0] d);
    int v, mag, p, frac, lg;
    logic s;
    v   = $signed(d);
    s   = (v < 0);
    mag = s ? -v : v;
    if (mag == 0) return {1'b0, 1'b1, 18'h20000};
    p = 0;
    for (int i = 0; i < 16; i++) if (mag >= (1 << i)) p = i;
    if (p >= 9) frac = (mag >> (p - 9)) & 511;
    else        frac = (mag << (9 - p)) & 511;
    lg = (p - 8) * 512 + frac;
    return {s, 1'b0, lg[17:0]};
  endfunction

  function automatic logic [15:0] rand_data();
    int r;
    r = $urandom_range(0, 7);
    if (r == 0) return 16'h0000;
    if (r == 1) return 16'h8000;
    if (r == 2) return 16'($signed($urandom_range(0, 6)) - 3);
    return 16'($urandom);
  endfunction

  // Monitor at the falling edge: scoreboard, stall stability and in_ready during stalls.
  initial begin
    logic [19:0] exp;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check("hold_valid", 32'(out_valid), 32'd1);
          check("hold_data", 32'({out_sign, out_zero, out_log}), 32'(held));
        end
        if (out_valid && !out_ready) check("stall_in_ready", 32'(in_ready), 32'd0);
        if (in_valid && in_ready) sb.push_back(model(in_data));
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
          end else begin
            exp = sb.pop_front();
            check("scoreboard", 32'({out_sign, out_zero, out_log}), 32'(exp));
          end
        end
        stall_prev = out_valid && !out_ready;
        held       = {out_sign, out_zero, out_log};
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  // Present one sample, then check the 3-cycle latency and the hand-computed result.
  task automatic send_one(input string tag, input logic [15:0] d, input logic [17:0] elog,
                          input logic esign, input logic ezero);
    in_data   = d;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_accept"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_lat1"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, "_lat2"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_log"}, 32'(out_log), 32'(elog));
    check({tag, "_sign"}, 32'(out_sign), 32'(esign));
    check({tag, "_zero"}, 32'(out_zero), 32'(ezero));
    @(posedge clk); #1;
  endtask

  initial begin
    logic [15:0] bp_vec[6];
    int idx, cyc, stall, n_in;
    logic seen, xfer;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    #3;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_log", 32'(out_log), 32'd0);
    check("rst_sign", 32'(out_sign), 32'd0);
    check("rst_zero", 32'(out_zero), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    send_one("one",    16'h0100, 18'h00000, 1'b0, 1'b0);
    send_one("three",  16'h0300, 18'h00300, 1'b0, 1'b0);
    send_one("negone", 16'hFF00, 18'h00000, 1'b1, 1'b0);
    send_one("mostneg", 16'h8000, 18'h00E00, 1'b1, 1'b0);
    send_one("lsb",    16'h0001, 18'h3F000, 1'b0, 1'b0);
    send_one("zero",   16'h0000, 18'h20000, 1'b0, 1'b1);

    // Backpressure: 6 samples back to back, with a 4-cycle stall after the first result.
    bp_vec = '{16'h0100, 16'h0300, 16'hFF00, 16'h8000, 16'h0001, 16'h7FFF};
    idx = 0; cyc = 0; stall = 0; seen = 1'b0;
    while ((idx < 6 || sb.size() > 0) && cyc < 100) begin
      in_valid  = (idx < 6);
      in_data   = (idx < 6) ? bp_vec[idx] : 16'h0000;
      out_ready = !(seen && stall < 4);
      @(negedge clk);
      xfer = in_valid && in_ready;
      if (out_valid && !seen) seen = 1'b1;
      else if (seen && !out_ready) stall++;
      @(posedge clk); #1;
      if (xfer) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    check("bp_cycles", 32'(cyc), 32'd13);
    check("bp_drained", 32'(sb.size()), 32'd0);

    // Reset mid-stream with three samples in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 16'h0100 << i;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_data", 32'({out_sign, out_zero, out_log}), 32'd0);
    @(posedge clk); #2;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    send_one("post_rst", 16'hFD00, 18'h00300, 1'b1, 1'b0);

    // Random stream with random valid/ready; the scoreboard checks every output.
    n_in = 0; cyc = 0;
    while (n_in < 10000 && cyc < 60000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = rand_data();
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_valid && in_ready) n_in++;
      @(posedge clk); #1;
      cyc++;
    end
    check("rand_sent", 32'(n_in), 32'd10000);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc = 0;
    while (sb.size() > 0 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("rand_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/lin2log_converter.md
Name: lin2log_converter

Overview:
- Pipelined linear-to-log front end that feeds the bit-shift log-domain adder.
- Converts a signed two's-complement fixed-point linear sample into sign-magnitude log2 form: an 18-bit log magnitude with 9 fraction bits, plus a sign bit.
- Uses the Mitchell approximation: leading-one detect, then the normalized mantissa is taken directly as the log fraction.
- Three-stage pipeline with valid/ready handshake on both sides; one conversion per cycle sustained.

Parameters:
- IN_W, 16, linear input width (signed two's complement).
- IN_FRAC, 8, fraction bits of the linear input.
- LOG_W, 18, log output width (signed two's complement).
- LOG_FRAC, 9, fraction bits of the log output; matches the adder's 9-bit shift.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  IN_W  signed linear sample.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  converter accepts in_data this cycle.
- out_log  output  LOG_W  signed log2 magnitude (LOG_FRAC fraction bits); drives the adder's X or Y.
- out_sign  output  1  sign of the linear sample (1 = negative); drives Sx or Sy.
- out_zero  output  1  linear sample was exactly zero.
- out_valid  output  1  out_* hold a valid result.
- out_ready  input  1  downstream accepts the result.

Behaviour:
- Reset (async, rst_n low): all stage valid bits 0, out_valid=0, out_log=0, out_sign=0, out_zero=0. Data registers cleared.
- Takes effect immediately and mid-operation. In-flight samples are discarded, not completed.
- Pipeline enable: en = !out_valid || out_ready. in_ready = en.
  - All three stages advance together when en=1 and hold when en=0.
  - Bubbles are not compressed.
- Transfer rules:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - out_* stable while out_valid && !out_ready.
- Latency: 3 cycles from accepting edge to out_valid, with no stall. Throughput: 1 per cycle when out_ready is held high.
- Stage 1 (sign/magnitude):
  - s = in_data[IN_W-1].
  - mag = s ? -in_data : in_data, as IN_W-bit unsigned. The most negative input gives mag = 2^(IN_W-1) with no overflow.
  - z = (mag==0).
- Stage 2 (leading-one detect): p = index of the highest set bit of mag, range 0..IN_W-1. p is don't-care when z=1.
- Stage 3 (assemble):
  - k = p - IN_FRAC, signed; range -8..7 at defaults.
  - If p >= LOG_FRAC: frac = mag[p-1 : p-LOG_FRAC], lower bits truncated with no rounding.
  - If p < LOG_FRAC: frac = mag[p-1:0] left-aligned into LOG_FRAC bits, zero-filled. p=0 gives frac=0.
  - out_log = (k << LOG_FRAC) + frac, sign-extended to LOG_W.
- Zero input:
  - out_log = most negative code, 18'h20000 at defaults.
  - out_zero=1, out_sign=0.
  - This code is the "-infinity" sentinel. It is treated as a normal operand by the adder: the difference saturates its shift to 0.
- Simultaneous accept and emit in the same cycle is legal and required for full throughput.
- in_valid deasserted while the pipeline advances inserts a bubble; out_valid follows 3 enabled cycles later.
- No internal state beyond the pipeline registers. No error outputs.

Test Plan:
- Basic conversions:
  - in_data=16'h0100 (1.0) -> out_log=18'h00000, out_sign=0, out_zero=0 on the 3rd edge after accept.
  - in_data=16'h0300 (3.0) -> out_log=18'h00300 (1.5 = 1 + 0.5), out_sign=0.
- Negatives and extremes:
  - in_data=16'hFF00 (-1.0) -> out_log=18'h00000, out_sign=1.
  - in_data=16'h8000 -> mag 32768, out_log=18'h00E00 (7.0), out_sign=1.
  - in_data=16'h0001 -> out_log=18'h3F000 (-8.0), out_sign=0.
- Zero: in_data=16'h0000 -> out_log=18'h20000, out_zero=1, out_sign=0.
- Backpressure:
  - Stream 6 samples back-to-back. Hold out_ready=0 for 4 cycles after the first out_valid.
  - Required: in_ready=0 during the stall, out_* frozen, no loss or duplication, results in order.
  - Full rate resumes once out_ready=1.
- Reset mid-stream: assert rst_n=0 asynchronously between edges with 3 samples in flight -> out_valid drops immediately, outputs go to 0. After release, the first new sample emerges exactly 3 cycles after accept.
- Randomized: 10k random in_data values with random valid/ready -> each output matches the Mitchell reference model bit-exactly, in order.
